// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and the datapath (slave).
interface mips_mc_control_if #(parameter int CNT_W = 32);
  logic [5:0]       Op;
  logic             MemReady;
  logic             PCwrite;
  logic             PCwriteCOND;
  logic [1:0]       PCsource;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRwrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;
  logic             IllegalOp;

  modport master (
    input  Op, MemReady,
    output PCwrite, PCwriteCOND, PCsource, IorD, MemRead, MemWrite, IRwrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           State, InstrCount, IllegalOp
  );

  modport slave (
    output Op, MemReady,
    input  PCwrite, PCwriteCOND, PCsource, IorD, MemRead, MemWrite, IRwrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           State, InstrCount, IllegalOp
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: state register with controls decoded from state
// (+MemReady); stalls on memory, counts retired instructions, traps illegal opcodes.
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input logic              Clk,
  input logic              Reset_n,
  mips_mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REX     = 4'd6,
    S_RWB     = 4'd7,
    S_BEQ     = 4'd8,
    S_JMP     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12,
    S_RST     = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t           state;
  state_t           nxt;
  logic             retire;
  logic [CNT_W-1:0] cnt;
  logic             illegal;

  always_comb begin
    nxt    = S_FETCH;
    retire = 1'b0;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_R:         nxt = S_REX;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BEQ;
          OP_J:         nxt = S_JMP;
          OP_ADDI:      nxt = S_ADDIEX;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      // Only lw/sw reach MEMADR, so anything but sw is a load
      S_MEMADR: nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  begin nxt = S_FETCH; retire = 1'b1; end
      S_MEMWR:  begin
        nxt    = bus.MemReady ? S_FETCH : S_MEMWR;
        retire = bus.MemReady;
      end
      S_REX:     nxt = S_RWB;
      S_RWB:     begin nxt = S_FETCH; retire = 1'b1; end
      S_BEQ:     begin nxt = S_FETCH; retire = 1'b1; end
      S_JMP:     begin nxt = S_FETCH; retire = 1'b1; end
      S_ADDIEX:  nxt = S_ADDIWB;
      S_ADDIWB:  begin nxt = S_FETCH; retire = 1'b1; end
      S_ILLEGAL: nxt = S_ILLEGAL;
      default:   nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_RST;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (retire) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state == S_ILLEGAL) illegal <= 1'b1;
    end
  end

  always_comb begin
    bus.PCwrite     = 1'b0;
    bus.PCwriteCOND = 1'b0;
    bus.PCsource    = 2'b00;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRwrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRwrite = bus.MemReady;
        bus.PCwrite = bus.MemReady;
      end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_REX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCwriteCOND = 1'b1;
        bus.PCsource    = 2'b01;
      end
      S_JMP: begin
        bus.PCwrite  = 1'b1;
        bus.PCsource = 2'b10;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign bus.State      = state;
  assign bus.InstrCount = cnt;
  assign bus.IllegalOp  = illegal;

endmodule

// File: tb/tb_mips_mc_control.sv
// Vector/scoreboard bench for mips_mc_control with a 4-bit retire counter.
module tb_mips_mc_control;

  localparam int CW = 4;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JJ = 6'b000010, ADDI = 6'b001000, RR = 6'b000000, BAD = 6'b111111;

  // {PCwrite,PCwriteCOND,PCsource,IorD,MemRead,MemWrite,IRwrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [15:0] Z    = 16'b0_0_00_0_0_0_0_0_0_0_0_00_00;
  localparam logic [15:0] FR   = 16'b1_0_00_0_1_0_1_0_0_0_0_01_00;
  localparam logic [15:0] FW   = 16'b0_0_00_0_1_0_0_0_0_0_0_01_00;
  localparam logic [15:0] DEC  = 16'b0_0_00_0_0_0_0_0_0_0_0_11_00;
  localparam logic [15:0] MADR = 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
  localparam logic [15:0] MRD  = 16'b0_0_00_1_1_0_0_0_0_0_0_00_00;
  localparam logic [15:0] MWB  = 16'b0_0_00_0_0_0_0_0_1_1_0_00_00;
  localparam logic [15:0] MWR  = 16'b0_0_00_1_0_1_0_0_0_0_0_00_00;
  localparam logic [15:0] REX  = 16'b0_0_00_0_0_0_0_0_0_0_1_00_10;
  localparam logic [15:0] RWB  = 16'b0_0_00_0_0_0_0_1_0_1_0_00_00;
  localparam logic [15:0] BQ   = 16'b0_1_01_0_0_0_0_0_0_0_1_00_01;
  localparam logic [15:0] JMP  = 16'b1_0_10_0_0_0_0_0_0_0_0_00_00;
  localparam logic [15:0] AWB  = 16'b0_0_00_0_0_0_0_0_0_1_0_00_00;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [3:0]  cnt;
    int          ill;   // 2 = not compared
  } vec_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   row = 0;
  vec_t tbl[$];
  vec_t sb[$];

  mips_mc_control_if #(.CNT_W(CW)) bus();
  mips_mc_control #(.CNT_W(CW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic mr,
                              input logic [3:0] st, input logic [15:0] ctl,
                              input logic [3:0] cnt, input int ill);
    vec_t v;
    v.rst_n = r; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.cnt = cnt; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL row%0d %s got=0x%0h want=0x%0h", row, name, got, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    logic [15:0] ctl;
    @(negedge Clk);
    Reset_n      = v.rst_n;
    bus.Op       = v.op;
    bus.MemReady = v.mr;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    ctl = {bus.PCwrite, bus.PCwriteCOND, bus.PCsource, bus.IorD, bus.MemRead, bus.MemWrite,
           bus.IRwrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};
    chk("state", 32'(bus.State), 32'(e.st));
    chk("ctl", 32'(ctl), 32'(e.ctl));
    chk("count", 32'(bus.InstrCount), 32'(e.cnt));
    if (e.ill != 2) chk("illegal", 32'(bus.IllegalOp), 32'(e.ill));
    if (bus.MemRead && bus.MemWrite) chk("rd_wr_exclusive", 32'd1, 32'd0);
    row++;
  endtask

  initial begin
    bus.Op = LW;
    bus.MemReady = 1'b0;

    // reset, lw, FETCH stall, beq, j
    tbl.push_back(mk(0, LW,  0, 13, Z,    0, 0));
    tbl.push_back(mk(1, LW,  1, 13, Z,    0, 0));
    tbl.push_back(mk(1, LW,  1, 0,  FR,   0, 0));
    tbl.push_back(mk(1, LW,  1, 1,  DEC,  0, 0));
    tbl.push_back(mk(1, LW,  1, 2,  MADR, 0, 0));
    tbl.push_back(mk(1, LW,  1, 3,  MRD,  0, 0));
    tbl.push_back(mk(1, LW,  1, 4,  MWB,  0, 0));
    tbl.push_back(mk(1, BEQ, 0, 0,  FW,   1, 0));
    tbl.push_back(mk(1, BEQ, 0, 0,  FW,   1, 0));
    tbl.push_back(mk(1, BEQ, 0, 0,  FW,   1, 0));
    tbl.push_back(mk(1, BEQ, 1, 0,  FR,   1, 0));
    tbl.push_back(mk(1, BEQ, 0, 1,  DEC,  1, 0));
    tbl.push_back(mk(1, BEQ, 0, 8,  BQ,   1, 0));
    tbl.push_back(mk(1, JJ,  1, 0,  FR,   2, 0));
    tbl.push_back(mk(1, JJ,  1, 1,  DEC,  2, 0));
    tbl.push_back(mk(1, JJ,  0, 9,  JMP,  2, 0));
    // sw with two stall cycles, addi, R-type
    tbl.push_back(mk(1, SW,  1, 0,  FR,   3, 0));
    tbl.push_back(mk(1, SW,  1, 1,  DEC,  3, 0));
    tbl.push_back(mk(1, SW,  1, 2,  MADR, 3, 0));
    tbl.push_back(mk(1, SW,  0, 5,  MWR,  3, 0));
    tbl.push_back(mk(1, SW,  0, 5,  MWR,  3, 0));
    tbl.push_back(mk(1, SW,  1, 5,  MWR,  3, 0));
    tbl.push_back(mk(1, ADDI,1, 0,  FR,   4, 0));
    tbl.push_back(mk(1, ADDI,1, 1,  DEC,  4, 0));
    tbl.push_back(mk(1, ADDI,1, 10, MADR, 4, 0));
    tbl.push_back(mk(1, ADDI,1, 11, AWB,  4, 0));
    tbl.push_back(mk(1, RR,  1, 0,  FR,   5, 0));
    tbl.push_back(mk(1, RR,  0, 1,  DEC,  5, 0));
    tbl.push_back(mk(1, RR,  0, 6,  REX,  5, 0));
    tbl.push_back(mk(1, RR,  0, 7,  RWB,  5, 0));
    // lw interrupted by async reset in MEMRD, then illegal opcode
    tbl.push_back(mk(1, LW,  1, 0,  FR,   6, 0));
    tbl.push_back(mk(1, LW,  1, 1,  DEC,  6, 0));
    tbl.push_back(mk(1, LW,  1, 2,  MADR, 6, 0));
    tbl.push_back(mk(1, LW,  0, 3,  MRD,  6, 0));
    tbl.push_back(mk(0, LW,  1, 13, Z,    0, 0));
    tbl.push_back(mk(1, BAD, 1, 13, Z,    0, 0));
    tbl.push_back(mk(1, BAD, 1, 0,  FR,   0, 0));
    tbl.push_back(mk(1, BAD, 1, 1,  DEC,  0, 0));
    tbl.push_back(mk(1, BAD, 1, 12, Z,    0, 2));

    foreach (tbl[i]) step(tbl[i]);

    // trapped: PC frozen and flag sticky regardless of MemReady
    for (int i = 0; i < 20; i++)
      step(mk(1, BAD, 1'($urandom_range(0, 1)), 12, Z, 0, 1));
    step(mk(0, BAD, 1, 13, Z, 0, 0));
    step(mk(1, RR,  1, 13, Z, 0, 0));

    // 16 R-types wrap the 4-bit counter 15 -> 0
    for (int i = 0; i < 16; i++) begin
      step(mk(1, RR, 1, 0, FR,  4'(i), 0));
      step(mk(1, RR, 1, 1, DEC, 4'(i), 0));
      step(mk(1, RR, 1, 6, REX, 4'(i), 0));
      step(mk(1, RR, 1, 7, RWB, 4'(i), 0));
    end
    step(mk(1, RR, 1, 0, FR, 4'd0, 0));

    if (sb.size() != 0) chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
